// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the skid-buffered pipeline stage:
//                stage state encoding, stage-word widths and field offsets.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Occupancy state of a stage. 2'd3 is not a legal encoding and the
    // stage logic recovers from it to S_EMPTY.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } stage_state_e;

    // IF/ID word: {instr, pc}
    localparam int IFID_W            = 64;
    localparam int IFID_PC_LSB       = 0;
    localparam int IFID_INSTR_LSB    = 32;

    // MEM/WB word: {rdata, alu, rd, mem_to_reg, reg_write}
    localparam int MEMWB_W           = 71;
    localparam int MEMWB_REGWR_BIT   = 0;
    localparam int MEMWB_MEM2REG_BIT = 1;
    localparam int MEMWB_RD_LSB      = 2;
    localparam int MEMWB_RD_W        = 5;
    localparam int MEMWB_ALU_LSB     = 7;
    localparam int MEMWB_RDATA_LSB   = 39;

    // Number of live entries held in a given state.
    function automatic logic [1:0] occupancy_of(input stage_state_e s);
        case (s)
            S_ONE:   occupancy_of = 2'd1;
            S_TWO:   occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at its all-ones value. Cleared only
//                by the asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Advance on inc unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Pipeline-stage register with valid/ready handshake, a
//                one-entry skid buffer, synchronous flush and a saturating
//                back-pressure counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W            = MEMWB_W,
    parameter bit FLUSH_CLEARS_DATA = 1'b0,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    logic in_fire;
    logic out_fire;
    logic stall_inc;

    // in_ready looks only at state (and reset) so downstream ready never
    // reaches upstream combinationally; the skid entry absorbs the lag.
    assign in_ready  = (state_q != S_TWO) & ~rst;
    assign out_valid = (state_q != S_EMPTY);
    assign occupancy = occupancy_of(state_q);
    assign out_data  = main_q;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stall_inc = out_valid & ~out_ready & ~flush;

    // Next-state and payload steering; flush overrides every fire.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
            if (FLUSH_CLEARS_DATA) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = S_TWO;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Directed and randomised self-checking bench. Two instances
//                share stimulus: A keeps payload on flush with a 16-bit
//                counter, B clears payload on flush with a 3-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready_a, out_valid_a;
    logic [DW-1:0] out_data_a;
    logic [1:0]    occ_a;
    logic [15:0]   stall_a;

    logic          in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_b;
    logic [1:0]    occ_b;
    logic [2:0]    stall_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .FLUSH_CLEARS_DATA(1'b0), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .occupancy(occ_a), .stall_cnt(stall_a)
    );

    pipe_stage_skid #(.DATA_W(DW), .FLUSH_CLEARS_DATA(1'b1), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occupancy(occ_b), .stall_cnt(stall_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [DW-1:0] sb[$];
        logic [DW-1:0] exp_d;
        logic          ir_before;
        logic          acc_last;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_out_valid_a", {31'd0, out_valid_a}, 32'd0);
        check("rst_in_ready_a",  {31'd0, in_ready_a},  32'd0);
        check("rst_occ_a",       {30'd0, occ_a},       32'd0);
        check("rst_out_data_a",  {16'd0, out_data_a},  32'd0);
        check("rst_stall_a",     {16'd0, stall_a},     32'd0);
        check("rst_in_ready_b",  {31'd0, in_ready_b},  32'd0);
        check("rst_out_valid_b", {31'd0, out_valid_b}, 32'd0);
        check("rst_occ_b",       {30'd0, occ_b},       32'd0);
        check("rst_stall_b",     {29'd0, stall_b},     32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready_a}, 32'd1);

        // ---------------- streaming 0x1..0x8 ----------------
        in_valid  = 1'b1;
        in_data   = 16'h1;
        out_ready = 1'b1;
        step();
        check("stream_first_valid", {31'd0, out_valid_a}, 32'd1);
        check("stream_first_data",  {16'd0, out_data_a},  32'h1);
        for (int k = 2; k <= 8; k++) begin
            in_data = DW'(k);
            step();
            check("stream_data", {16'd0, out_data_a}, k);
            check("stream_occ",  {30'd0, occ_a},      32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", {31'd0, out_valid_a}, 32'd0);
        check("stream_no_stall", {16'd0, stall_a},    32'd0);

        // ---------------- back-pressure with 0xA / 0xB ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hA;
        step();
        check("bp_occ1",      {30'd0, occ_a},      32'd1);
        check("bp_in_ready1", {31'd0, in_ready_a}, 32'd1);
        in_data = 16'hB;
        step();
        in_valid = 1'b0;
        check("bp_occ2",      {30'd0, occ_a},      32'd2);
        check("bp_in_ready0", {31'd0, in_ready_a}, 32'd0);
        check("bp_head_A",    {16'd0, out_data_a}, 32'hA);
        check("bp_stall1",    {16'd0, stall_a},    32'd1);
        step();
        check("bp_stall2",    {16'd0, stall_a},    32'd2);
        check("bp_hold_occ2", {30'd0, occ_a},      32'd2);
        out_ready = 1'b1;
        step();
        check("bp_head_B",    {16'd0, out_data_a}, 32'hB);
        check("bp_occ_back1", {30'd0, occ_a},      32'd1);
        step();
        check("bp_empty",     {30'd0, occ_a},      32'd0);
        check("bp_stall_a",   {16'd0, stall_a},    32'd2);
        check("bp_stall_b",   {29'd0, stall_b},    32'd2);

        // ---------------- flush in TWO with 0xC / 0xD, offering 0xE ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hC;
        step();
        in_data = 16'hD;
        step();
        check("fl_two", {30'd0, occ_a}, 32'd2);
        flush   = 1'b1;
        in_data = 16'hE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ0",      {30'd0, occ_a},       32'd0);
        check("fl_valid0",    {31'd0, out_valid_a}, 32'd0);
        check("fl_keep_data", {16'd0, out_data_a},  32'hC);
        check("fl_clear_b",   {16'd0, out_data_b},  32'd0);
        check("fl_stall_a",   {16'd0, stall_a},     32'd3);
        out_ready = 1'b1;
        step();
        step();
        check("fl_no_E", {31'd0, out_valid_a}, 32'd0);

        // ---------------- flush in ONE while an entry is accepted ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h11;
        step();
        check("fl1_one", {30'd0, occ_a}, 32'd1);
        flush   = 1'b1;
        in_data = 16'h12;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl1_occ0",    {30'd0, occ_a},      32'd0);
        check("fl1_clear_b", {16'd0, out_data_b}, 32'd0);
        check("fl1_stall_a", {16'd0, stall_a},    32'd3);
        step();
        check("fl1_discard", {31'd0, out_valid_a}, 32'd0);

        // ---------------- saturation of the 3-bit counter ----------------
        in_valid = 1'b1;
        in_data  = 16'h21;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3) check("sat_b_6", {29'd0, stall_b}, 32'd6);
            if (k == 4) check("sat_b_7", {29'd0, stall_b}, 32'd7);
        end
        check("sat_b_hold", {29'd0, stall_b}, 32'd7);
        check("sat_a_15",   {16'd0, stall_a}, 32'd15);
        out_ready = 1'b1;
        step();
        check("sat_drain", {30'd0, occ_a}, 32'd0);

        // ---------------- asynchronous reset in TWO ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h31;
        step();
        in_data = 16'h32;
        step();
        in_valid = 1'b0;
        check("ar_two", {30'd0, occ_a}, 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid0", {31'd0, out_valid_a}, 32'd0);
        check("ar_ready0", {31'd0, in_ready_a},  32'd0);
        check("ar_occ0",   {30'd0, occ_a},       32'd0);
        check("ar_data0",  {16'd0, out_data_a},  32'd0);
        check("ar_stall0", {16'd0, stall_a},     32'd0);
        check("ar_stallb", {29'd0, stall_b},     32'd0);
        step();
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h41;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("ar_first_valid", {31'd0, out_valid_a}, 32'd1);
        check("ar_first_data",  {16'd0, out_data_a},  32'h41);
        step();
        check("ar_drain", {30'd0, occ_a}, 32'd0);

        // ---------------- random traffic with scoreboard ----------------
        acc_last = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if (!(in_valid && !acc_last)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = DW'($urandom);
            end
            out_ready = 1'b0;
            #1;
            ir_before = in_ready_a;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rnd_ready_indep", {31'd0, in_ready_a}, {31'd0, ir_before});
            if (out_valid_a && out_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_d = sb.pop_front();
                    check("rnd_order", {16'd0, out_data_a}, {16'd0, exp_d});
                end
            end
            acc_last = in_valid && in_ready_a;
            if (acc_last) sb.push_back(in_data);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid_a && sb.size() != 0) begin
                exp_d = sb.pop_front();
                check("drain_order", {16'd0, out_data_a}, {16'd0, exp_d});
            end
            step();
        end
        check("rnd_sb_empty", sb.size(), 32'd0);
        check("rnd_occ_end",  {30'd0, occ_a}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating back-pressure counter. It is the successor to the fixed-field stage registers between pipeline stages (IF/ID through MEM/WB) in the RISC-V core. Each stage's fields are packed into one `DATA_W`-bit word, and a single instance replaces one hand-written stage register. Unlike those registers, it can stall, drop squashed instructions and decouple upstream ready from downstream ready.

## Interface
- `DATA_W`, 71, payload width. The default is MEM/WB packing: 32 read data + 32 ALU result + 5 rd + Mem_to_Reg + Reg_Write.
- `FLUSH_CLEARS_DATA`, 0, when 1 a flush also zeroes both payload registers.
- `CNT_W`, 16, width of the stall counter.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous squash of all held and incoming entries.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: stage can accept this cycle.
- `in_data` input `DATA_W`: upstream payload.
- `out_valid` output 1: `out_data` holds a live entry.
- `out_ready` input 1: downstream consumes this cycle.
- `out_data` output `DATA_W`: head payload.
- `occupancy` output 2: number of live entries, 0..2.
- `stall_cnt` output `CNT_W`: cycles spent back-pressured.

## Operation
- Handshakes:
  - Input fire = `in_valid & in_ready`.
  - Output fire = `out_valid & out_ready`.
  - `in_valid` and `in_data` must stay stable while `in_valid & !in_ready`. The bench asserts this; the RTL does not check it.
- Storage is two registers: `main` (head, drives `out_data`) and `skid`.
- State machine, with states EMPTY / ONE / TWO:
  - EMPTY: input fire loads `main` and moves to ONE.
  - ONE, input fire and output fire: load `main` from `in_data` and stay in ONE.
  - ONE, input fire only: load `skid` and move to TWO.
  - ONE, output fire only: move to EMPTY.
  - ONE, neither: hold.
  - TWO: output fire copies `skid` into `main` and moves to ONE. Otherwise hold.
- Output decode:
  - `out_valid` = state != EMPTY.
  - `in_ready` = (state != TWO) & !`rst`.
  - `in_ready` is a function of state only, with no combinational path from `out_ready`.
  - `occupancy` = 0, 1 or 2 per state.
- Flush:
  - Flush has the highest priority. On a flush edge the state goes to EMPTY regardless of fires.
  - An entry accepted on that edge is discarded, and a downstream fire on that edge still counts as consumed.
  - Payload registers are zeroed only when `FLUSH_CLEARS_DATA`=1.
- `stall_cnt`:
  - Increments on every edge with `out_valid & !out_ready & !flush`.
  - Saturates at 2^`CNT_W`-1.
  - Cleared only by `rst`.
- Ordering is strictly FIFO: entries leave in acceptance order, with no duplication or loss except through flush.

## Timing
- Latency: an entry accepted at edge N into EMPTY is on `out_data` with `out_valid`=1 after edge N.
- Throughput: one entry per cycle sustained while `out_ready`=1.
- Back-pressure: `in_ready` drops exactly one edge after `out_ready` falls, if upstream kept sending. Skid capacity covers that cycle.
- Reset:
  - Asynchronous assertion immediately forces state EMPTY, `main`=`skid`=0 and `stall_cnt`=0.
  - During reset, outputs are `out_valid`=0, `in_ready`=0, `occupancy`=0 and `out_data`=0.
  - First acceptance can happen at the first rising edge after `rst` deasserts.
- Reset mid-operation loses all entries; no partial state survives.
- Simultaneous `flush` and `rst`: reset wins.

## Structure
- Shared package `pipe_pkg` holds:
  - the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2; 2'd3 is illegal and recovers to EMPTY);
  - `localparam` packing widths and field offsets for each stage word, so stage-field positions are defined once.
- One sub-module: `sat_counter` (parameter `W`; ports clk, rst, inc, count), instantiated for `stall_cnt`.
- Field pack/unpack stays at the instantiating stage, not inside this block.

## Test plan
- Reset, then `in_valid`=1 with `in_data`=0x1, `out_ready`=1 -> `out_data`=0x1 and `out_valid`=1 after one edge, then one output per cycle for 0x1..0x8.
- `out_ready`=0 while 0xA and 0xB are sent:
  - `occupancy` goes 1 then 2, and `in_ready`=0.
  - Releasing `out_ready` yields 0xA then 0xB in order.
  - `stall_cnt` equals the stalled cycles.
- Random `in_valid`/`out_ready` (50%, 10k cycles) -> scoreboard shows no loss, duplication or reorder, and `in_ready` never depends on same-cycle `out_ready`.
- State TWO holding 0xC/0xD, pulse `flush` with `in_valid`=1 and `in_data`=0xE -> next cycle `occupancy`=0, `out_valid`=0, and 0xE is never delivered. With `FLUSH_CLEARS_DATA`=1, `out_data`=0.
- `CNT_W`=3 with `out_ready` held low for 12 cycles with one entry -> `stall_cnt` saturates at 7 and holds.
- Assert `rst` asynchronously mid-cycle in state TWO -> outputs go to reset values before the next edge, and the first entry after deassert appears with 1-cycle latency.
